matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Sequences one square matrix multiply C = A x B for the UART matrix engine.
//  Reads A and B from the operand buffers, accumulates dot products and writes C to the result buffer.
//  Started by the top-level control FSM's COMPUTE level (start); returns a done pulse (mult_done).
//  Sits between the control unit and the A/B/C buffers. Matrices are unsigned, row-major.
// PARAMETERS
//  N_MAX  8   largest supported matrix dimension
//  AW     6   buffer address width; must satisfy 2**AW >= N_MAX*N_MAX
//  DW     8   operand width (unsigned)
//  ACCW   20  accumulator/result width; wraps modulo 2**ACCW
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  start      in   1     level request from control FSM; accepted only when armed in IDLE
//  size       in   4     matrix dimension n; sampled on accept
//  busy       out  1     high from the cycle after accept through the DONE cycle
//  done       out  1     one-cycle completion pulse
//  err        out  1     held high after a bad-size request; cleared by the next accept
//  rd_en      out  1     read strobe to the A and B buffers
//  a_addr     out  AW    A read address = i*n + k
//  b_addr     out  AW    B read address = k*n + j
//  a_data     in   DW    A read data, valid exactly 1 cycle after rd_en
//  b_data     in   DW    B read data, valid exactly 1 cycle after rd_en
//  c_we       out  1     C write strobe, single cycle
//  c_addr     out  AW    C write address = i*n + j
//  c_data     out  ACCW  C write data (accumulator value)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, armed=1, i/j/k counters 0, acc 0.
//  States: IDLE, ISSUE, DRAIN, WRITE, DONE.
//  IDLE:
//   - accept = start & armed. On accept latch n=size and clear err.
//   - If n==0 or n>N_MAX: set err=1, go DONE with no reads and no writes.
//   - Otherwise i=j=k=0 and go ISSUE.
//   - armed clears in DONE and re-sets in any IDLE cycle with start==0.
//   - A level start held through done does not restart the block.
//  ISSUE: rd_en=1 with a_addr/b_addr from the current (i,j,k); k increments each cycle.
//   - After k==n-1 is issued, go DRAIN.
//  Accumulate: one cycle after each rd_en, acc <= (first_k ? 0 : acc) + a_data*b_data.
//   - The product is full 2*DW width, zero-extended or truncated to ACCW.
//   - first_k is the rd_en k==0 flag, delayed one cycle.
//  DRAIN: one cycle. Absorbs the last product (k==n-1); rd_en=0.
//  WRITE: one cycle. c_we=1, c_addr=i*n+j, c_data=acc. Then advance j, wrapping to 0 and incrementing i.
//   - If (i,j)==(n-1,n-1), go DONE; otherwise reset k=0 and go ISSUE.
//  DONE: done=1 and busy=1 for one cycle, then IDLE.
//  Latency:
//   - Each C element takes n+2 cycles. Total accept-to-done = n*n*(n+2)+1 cycles.
//   - For n=1 that is 4 cycles. Bad size: done on the cycle after accept.
//  c_we, done and rd_en are never high in the same cycle. c_addr/c_data hold their last value when c_we=0.
//  start changes while busy are ignored; size changes after accept are ignored.
//  Address arithmetic is done at AW bits. All results are < N_MAX*N_MAX, so there is no wrap.
//  Reset asserted mid-operation: immediate return to reset values, no further c_we.
//   - A partially written C is not cleaned up.
// TESTING
//  n=1, A=[7], B=[9], start held high:
//   - exactly one c_we, c_addr=0, c_data=63.
//   - done 4 cycles after accept.
//   - no second run until start drops.
//  n=2, A=[1 2;3 4], B=[5 6;7 8]:
//   - C writes in order addr 0..3 = 19,22,43,50.
//   - done at accept+17.
//  n=8, all operands 255:
//   - 64 writes, each c_data=8*65025=520200 mod 2^20 = 520200.
//   - done at accept+641.
//  size=0, then size=9:
//   - each gives done one cycle after accept with err=1.
//   - rd_en and c_we never assert.
//  n=3 with rst pulsed during the 5th element:
//   - outputs zero during rst, no c_we afterwards.
//   - a fresh start with n=2 completes correctly.
//  Toggle start and size while busy (n=3):
//   - ignored; 9 writes; done at accept+46.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequences one square matrix multiply C = A x B over the A/B operand buffers and the C result buffer.
// Each C element is one pass of n reads, one drain cycle for the read latency, and one write.
module matmul_sequencer #(
    parameter int unsigned N_MAX = 8,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACCW  = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      size,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            rd_en,
    output logic [AW-1:0]   a_addr,
    output logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   a_data,
    input  logic [DW-1:0]   b_data,
    output logic            c_we,
    output logic [AW-1:0]   c_addr,
    output logic [ACCW-1:0] c_data
);

    localparam int unsigned CW = 4;
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic            armed, armed_nx;
    logic [CW-1:0]   n, n_nx;
    logic [CW-1:0]   i, i_nx;
    logic [CW-1:0]   j, j_nx;
    logic [CW-1:0]   k, k_nx;
    logic [ACCW-1:0] acc, acc_nx;
    logic            vld, vld_nx;
    logic            first, first_nx;
    logic [PW-1:0]   prod;
    logic [ACCW-1:0] acc_base;

    logic            busy_nx, done_nx, err_nx, rd_en_nx, c_we_nx;
    logic [AW-1:0]   a_addr_nx, b_addr_nx, c_addr_nx;
    logic [ACCW-1:0] c_data_nx;

    // State, counters, accumulator and all outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            armed  <= 1'b1;
            n      <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            vld    <= 1'b0;
            first  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            rd_en  <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
            c_we   <= 1'b0;
            c_addr <= '0;
            c_data <= '0;
        end else begin
            state  <= state_nx;
            armed  <= armed_nx;
            n      <= n_nx;
            i      <= i_nx;
            j      <= j_nx;
            k      <= k_nx;
            acc    <= acc_nx;
            vld    <= vld_nx;
            first  <= first_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            err    <= err_nx;
            rd_en  <= rd_en_nx;
            a_addr <= a_addr_nx;
            b_addr <= b_addr_nx;
            c_we   <= c_we_nx;
            c_addr <= c_addr_nx;
            c_data <= c_data_nx;
        end
    end

    // Next-state, counter, accumulate and output-next logic
    always_comb begin
        state_nx  = state;
        armed_nx  = armed;
        n_nx      = n;
        i_nx      = i;
        j_nx      = j;
        k_nx      = k;
        err_nx    = err;
        a_addr_nx = a_addr;
        b_addr_nx = b_addr;
        c_addr_nx = c_addr;
        c_data_nx = c_data;

        // Read data returns one cycle after rd_en; first marks the k==0 product
        vld_nx   = rd_en;
        first_nx = rd_en && (k == '0);
        prod     = PW'(a_data) * PW'(b_data);
        acc_base = first ? '0 : acc;
        acc_nx   = vld ? (acc_base + ACCW'(prod)) : acc;

        case (state)
            IDLE: begin
                if (!start) begin
                    armed_nx = 1'b1;
                end
                if (start && armed) begin
                    n_nx   = size;
                    err_nx = 1'b0;
                    i_nx   = '0;
                    j_nx   = '0;
                    k_nx   = '0;
                    if (size == '0 || 32'(size) > N_MAX) begin
                        err_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (k == n - CW'(1)) begin
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + CW'(1);
                end
            end
            DRAIN: begin
                state_nx  = WRITE;
                c_addr_nx = AW'(i) * AW'(n) + AW'(j);
                c_data_nx = acc_nx;
            end
            WRITE: begin
                k_nx     = '0;
                state_nx = ISSUE;
                if (j == n - CW'(1)) begin
                    j_nx = '0;
                    if (i == n - CW'(1)) begin
                        state_nx = DONE;
                    end else begin
                        i_nx = i + CW'(1);
                    end
                end else begin
                    j_nx = j + CW'(1);
                end
            end
            DONE: begin
                armed_nx = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        rd_en_nx = (state_nx == ISSUE);
        c_we_nx  = (state_nx == WRITE);
        done_nx  = (state_nx == DONE);
        busy_nx  = (state_nx != IDLE);
        if (rd_en_nx) begin
            a_addr_nx = AW'(i_nx) * AW'(n_nx) + AW'(k_nx);
            b_addr_nx = AW'(k_nx) * AW'(n_nx) + AW'(j_nx);
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: buffer model with one-cycle read latency,
// expected C writes queued from an integer matrix model and popped on every c_we.
`timescale 1ns/1ps
module tb_matmul_sequencer;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACCW  = 20;
    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [ACCW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [3:0]      size;
    logic            busy, done, err, rd_en, c_we;
    logic [AW-1:0]   a_addr, b_addr, c_addr;
    logic [DW-1:0]   a_data, b_data;
    logic [ACCW-1:0] c_data;

    logic [DW-1:0]   a_mem [DEPTH];
    logic [DW-1:0]   b_mem [DEPTH];
    wr_t             exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.N_MAX(8), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .size   (size),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rd_en  (rd_en),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_data (a_data),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_data (c_data)
    );

    // A/B buffers: data valid exactly one cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end
    end

    task automatic push_expected(input int n);
        int s;
        wr_t e;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int m = 0; m < n; m++) begin
                    s = s + int'(a_mem[r*n+m]) * int'(b_mem[m*n+c]);
                end
                e.addr = AW'(r*n + c);
                e.data = ACCW'(s);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle_cycles(input int cnt);
        for (int c = 0; c < cnt; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; size = '0;
        idle_cycles(3);
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b, want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b, want 0", done); end
        n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL reset_err: got %b, want 0", err); end
        n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b, want 0", rd_en); end
        n_cmp++; if (c_we !== 1'b0)  begin n_bad++; $display("FAIL reset_c_we: got %b, want 0", c_we); end
        n_cmp++; if (a_addr !== '0 || b_addr !== '0) begin
            n_bad++; $display("FAIL reset_rd_addr: got a=%0d b=%0d, want 0 0", a_addr, b_addr);
        end
        n_cmp++; if (c_addr !== '0 || c_data !== '0) begin
            n_bad++; $display("FAIL reset_c_bus: got addr=%0d data=%0d, want 0 0", c_addr, c_data);
        end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    // One full multiply; hold keeps start high through and after done, toggle scrambles start/size while busy
    task automatic test_matmul(input string tag, input int n, input bit hold, input bit toggle);
        int  lat, cyc, nwr, nrd, ovl, busy_gap, hold_bad, extra;
        bit  got_done;
        wr_t e;
        logic [AW-1:0]   la;
        logic [ACCW-1:0] ld;
        lat = n*n*(n+2) + 1;
        exp_q.delete();
        push_expected(n);
        @(negedge clk);
        start = 1'b1; size = 4'(n);
        cyc = 0; nwr = 0; nrd = 0; ovl = 0; busy_gap = 0; hold_bad = 0; got_done = 1'b0;
        la = '0; ld = '0;
        while (!got_done && cyc < lat + 20) begin
            @(negedge clk);
            cyc++;
            if (c_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_write: got addr=%0d data=%0d, want no write", tag, c_addr, c_data);
                end else begin
                    e = exp_q.pop_front();
                    if (c_addr !== e.addr || c_data !== e.data) begin
                        n_bad++;
                        $display("FAIL %s write%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                                 tag, nwr, c_addr, c_data, e.addr, e.data);
                    end
                end
                la = c_addr; ld = c_data;
                nwr++;
            end else if (nwr > 0 && (c_addr !== la || c_data !== ld)) begin
                hold_bad++;
            end
            if (rd_en) nrd++;
            if (int'(c_we) + int'(done) + int'(rd_en) > 1) ovl++;
            if (!busy) busy_gap++;
            if (done) begin
                got_done = 1'b1;
                n_cmp++;
                if (err !== 1'b0) begin n_bad++; $display("FAIL %s err_at_done: got %b, want 0", tag, err); end
            end
            if (toggle) begin
                start = 1'($urandom);
                size  = 4'($urandom);
            end else if (!hold) begin
                start = 1'b0;
            end
        end
        if (!hold) start = 1'b0;
        n_cmp++;
        if (!got_done || cyc != lat) begin
            n_bad++; $display("FAIL %s done_latency: got %0d (seen=%0b), want %0d", tag, cyc, got_done, lat);
        end
        n_cmp++; if (nwr != n*n)   begin n_bad++; $display("FAIL %s write_count: got %0d, want %0d", tag, nwr, n*n); end
        n_cmp++; if (nrd != n*n*n) begin n_bad++; $display("FAIL %s read_count: got %0d, want %0d", tag, nrd, n*n*n); end
        n_cmp++; if (ovl != 0)      begin n_bad++; $display("FAIL %s strobe_overlap: got %0d cycles, want 0", tag, ovl); end
        n_cmp++; if (busy_gap != 0) begin n_bad++; $display("FAIL %s busy_gap: got %0d cycles, want 0", tag, busy_gap); end
        n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL %s c_hold: got %0d changes, want 0", tag, hold_bad); end
        n_cmp++; if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL %s missing_writes: got %0d left, want 0", tag, exp_q.size());
        end
        if (hold) begin
            extra = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rd_en || c_we || done || busy) extra++;
            end
            n_cmp++;
            if (extra != 0) begin n_bad++; $display("FAIL %s held_start_restart: got %0d active cycles, want 0", tag, extra); end
            start = 1'b0;
        end
        idle_cycles(3);
    endtask

    task automatic test_start_held();
        a_mem[0] = 8'd7;
        b_mem[0] = 8'd9;
        test_matmul("n1_held", 1, 1'b1, 1'b0);
    endtask

    task automatic test_n2();
        for (int x = 0; x < 4; x++) begin
            a_mem[x] = 8'(x + 1);
            b_mem[x] = 8'(x + 5);
        end
        test_matmul("n2", 2, 1'b0, 1'b0);
    endtask

    task automatic test_full_scale();
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = 8'd255;
            b_mem[x] = 8'd255;
        end
        test_matmul("n8_max", 8, 1'b0, 1'b0);
    endtask

    task automatic test_bad_size(input int sz);
        int cyc, act;
        bit got_done;
        @(negedge clk);
        start = 1'b1; size = 4'(sz);
        cyc = 0; act = 0; got_done = 1'b0;
        while (!got_done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (rd_en || c_we) act++;
            if (done) begin
                got_done = 1'b1;
                n_cmp++;
                if (err !== 1'b1 || busy !== 1'b1) begin
                    n_bad++; $display("FAIL bad%0d flags_at_done: got err=%b busy=%b, want 1 1", sz, err, busy);
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!got_done || cyc != 1) begin
            n_bad++; $display("FAIL bad%0d done_latency: got %0d (seen=%0b), want 1", sz, cyc, got_done);
        end
        idle_cycles(4);
        n_cmp++; if (act != 0)   begin n_bad++; $display("FAIL bad%0d bus_activity: got %0d, want 0", sz, act); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad%0d err_held: got %b, want 1", sz, err); end
    endtask

    task automatic test_reset_midop();
        int  cyc, nwr, post, after4;
        wr_t e;
        for (int x = 0; x < 9; x++) begin
            a_mem[x] = 8'($urandom_range(0, 255));
            b_mem[x] = 8'($urandom_range(0, 255));
        end
        exp_q.delete();
        push_expected(3);
        @(negedge clk);
        start = 1'b1; size = 4'd3;
        cyc = 0; nwr = 0; after4 = 0;
        while (after4 < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (nwr == 4) after4++;
            if (c_we) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (c_addr !== e.addr || c_data !== e.data) begin
                    n_bad++;
                    $display("FAIL midrst write%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             nwr, c_addr, c_data, e.addr, e.data);
                end
                nwr++;
            end
        end
        n_cmp++;
        if (nwr != 4) begin n_bad++; $display("FAIL midrst pre_writes: got %0d, want 4", nwr); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || c_we !== 1'b0 || done !== 1'b0 ||
            a_addr !== '0 || c_addr !== '0 || c_data !== '0) begin
            n_bad++;
            $display("FAIL midrst outputs_in_rst: got busy=%b rd=%b we=%b done=%b a=%0d caddr=%0d cdata=%0d, want all 0",
                     busy, rd_en, c_we, done, a_addr, c_addr, c_data);
        end
        idle_cycles(2);
        rst = 1'b0;
        exp_q.delete();
        post = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c_we || rd_en || busy) post++;
        end
        n_cmp++;
        if (post != 0) begin n_bad++; $display("FAIL midrst activity_after_rst: got %0d cycles, want 0", post); end
        for (int x = 0; x < 4; x++) begin
            a_mem[x] = 8'($urandom_range(0, 255));
            b_mem[x] = 8'($urandom_range(0, 255));
        end
        test_matmul("post_rst_n2", 2, 1'b0, 1'b0);
    endtask

    task automatic test_busy_toggle();
        for (int x = 0; x < 9; x++) begin
            a_mem[x] = 8'($urandom_range(0, 255));
            b_mem[x] = 8'($urandom_range(0, 255));
        end
        test_matmul("n3_toggle", 3, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; size = '0;
        test_reset();
        test_start_held();
        test_n2();
        test_full_scale();
        test_bad_size(0);
        test_bad_size(9);
        test_reset_midop();
        test_busy_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
